banco_registradores_multiporta: RTL and testbench

// - Parametrised register file for the RISC-V core. Successor to the fixed 32x32 two-read/one-write bank.
// - Configurable width, depth and read-port count. Two write ports with fixed priority.
// - Optional write-to-read bypass, optional hardwired zero register.
// - Sequenced clear FSM zeroes all entries after reset or on a soft clear request.

---
 rtl/banco_registradores_multiporta_if.sv | 28 ++
 rtl/banco_registradores_multiporta.sv | 109 ++++++++++
 tb/tb_banco_registradores_multiporta.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/banco_registradores_multiporta_if.sv
// Bus bundle for the multi-port register file: soft clear, two write ports,
// packed read ports and the busy flag.
interface banco_registradores_multiporta_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2
);
    logic                         clear;
    logic                         we0;
    logic [ADDR_W-1:0]            waddr0;
    logic [DATA_W-1:0]            wdata0;
    logic                         we1;
    logic [ADDR_W-1:0]            waddr1;
    logic [DATA_W-1:0]            wdata1;
    logic [NUM_READ*ADDR_W-1:0]   raddr;
    logic [NUM_READ*DATA_W-1:0]   rdata;
    logic                         busy;

    modport master (
        output clear, we0, waddr0, wdata0, we1, waddr1, wdata1, raddr,
        input  rdata, busy
    );

    modport slave (
        input  clear, we0, waddr0, wdata0, we1, waddr1, wdata1, raddr,
        output rdata, busy
    );
endinterface

// File: rtl/banco_registradores_multiporta.sv
// Parametrised multi-port register file: N combinational read ports, two
// prioritised write ports, optional bypass/zero register and a sequenced clear.
module banco_registradores_multiporta #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic clk,
    input logic reset,
    banco_registradores_multiporta_if.slave bus
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [ADDR_W:0]   NUM_REGS_EXT = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] clrIdx;
    logic [ADDR_W-1:0] clrIdxNext;
    logic              wr0Ok;
    logic              wr1Ok;
    logic [NUM_READ*DATA_W-1:0] rdataComb;

    // Sized to the full address space so any address indexes cleanly;
    // entries at or above NUM_REGS are never written nor read.
    logic [DATA_W-1:0] regs [2**ADDR_W];

    function automatic logic addrUsable(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NUM_REGS_EXT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr0Ok = bus.we0 && addrUsable(bus.waddr0);
    assign wr1Ok = bus.we1 && addrUsable(bus.waddr1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= CLEAR;
            clrIdx <= '0;
        end else begin
            state  <= stateNext;
            clrIdx <= clrIdxNext;
        end
    end

    always_comb begin
        stateNext  = state;
        clrIdxNext = clrIdx;
        case (state)
            CLEAR: begin
                clrIdxNext = clrIdx + 1'b1;
                if (clrIdx == LAST_IDX) begin
                    stateNext = READY;
                end
            end
            READY: begin
                if (bus.clear) begin
                    stateNext  = CLEAR;
                    clrIdxNext = '0;
                end
            end
            default: begin
                stateNext  = CLEAR;
                clrIdxNext = '0;
            end
        endcase
    end

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                regs[clrIdx] <= '0;
            end else if (state == READY) begin
                if (wr0Ok) regs[bus.waddr0] <= bus.wdata0;
                if (wr1Ok) regs[bus.waddr1] <= bus.wdata1;
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] word;
        rdataComb = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            ra   = bus.raddr[k*ADDR_W +: ADDR_W];
            word = '0;
            if ((state == READY) && addrUsable(ra)) begin
                word = regs[ra];
                if (BYPASS != 0) begin
                    if (wr1Ok && (bus.waddr1 == ra)) begin
                        word = bus.wdata1;
                    end else if (wr0Ok && (bus.waddr0 == ra)) begin
                        word = bus.wdata0;
                    end
                end
            end
            rdataComb[k*DATA_W +: DATA_W] = word;
        end
    end

    assign bus.rdata = rdataComb;
    assign bus.busy  = (state == CLEAR);

endmodule

// File: tb/tb_banco_registradores_multiporta.sv
// Bench for the multi-port register file: two configurations driven together
// and checked every cycle against an array-based model, plus literal checks.
module tb_banco_registradores_multiporta;

    logic clk;
    logic reset;
    logic clear;

    banco_registradores_multiporta_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) ifA ();
    banco_registradores_multiporta_if #(.DATA_W(32), .ADDR_W(6), .NUM_READ(3)) ifB ();

    banco_registradores_multiporta #(
        .DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)
    ) dutA (.clk(clk), .reset(reset), .bus(ifA));

    banco_registradores_multiporta #(
        .DATA_W(32), .NUM_REGS(40), .ADDR_W(6), .NUM_READ(3), .ZERO_REG(0), .BYPASS(0)
    ) dutB (.clk(clk), .reset(reset), .bus(ifB));

    assign ifA.clear = clear;
    assign ifB.clear = clear;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Configuration of the two instances, index 0 = A, 1 = B.
    function automatic int nr(int d);   return (d == 0) ? 32 : 40; endfunction
    function automatic bit zr(int d);   return (d == 0);           endfunction
    function automatic bit byp(int d);  return (d == 0);           endfunction
    function automatic int nrd(int d);  return (d == 0) ? 2 : 3;   endfunction

    // Model state.
    logic [31:0] mem [2][64];
    bit          mBusy [2];
    int          mLeft [2];
    bit          mValid = 0;

    // Snapshot of the inputs presented this cycle.
    bit          sReset, sClear;
    bit          sWe0 [2];
    bit          sWe1 [2];
    int          sWa0 [2];
    int          sWa1 [2];
    logic [31:0] sWd0 [2];
    logic [31:0] sWd1 [2];
    int          sRa  [2][3];

    function automatic bit okAddr(int d, int a);
        return (a < nr(d)) && !(zr(d) && a == 0);
    endfunction

    function automatic logic [31:0] rd(int d, int k);
        if (d == 0) return ifA.rdata[k*32 +: 32];
        return ifB.rdata[k*32 +: 32];
    endfunction

    function automatic logic busyOf(int d);
        return (d == 0) ? ifA.busy : ifB.busy;
    endfunction

    function automatic logic [31:0] expRead(int d, int a);
        if (mBusy[d] || !okAddr(d, a)) return 32'h0;
        if (byp(d)) begin
            if (sWe1[d] && okAddr(d, sWa1[d]) && sWa1[d] == a) return sWd1[d];
            if (sWe0[d] && okAddr(d, sWa0[d]) && sWa0[d] == a) return sWd0[d];
        end
        return mem[d][a];
    endfunction

    task automatic snap();
        sReset = reset;
        sClear = clear;
        sWe0[0] = ifA.we0; sWa0[0] = int'(ifA.waddr0); sWd0[0] = ifA.wdata0;
        sWe1[0] = ifA.we1; sWa1[0] = int'(ifA.waddr1); sWd1[0] = ifA.wdata1;
        sWe0[1] = ifB.we0; sWa0[1] = int'(ifB.waddr0); sWd0[1] = ifB.wdata0;
        sWe1[1] = ifB.we1; sWa1[1] = int'(ifB.waddr1); sWd1[1] = ifB.wdata1;
        for (int k = 0; k < 2; k++) sRa[0][k] = int'(ifA.raddr[k*5 +: 5]);
        sRa[0][2] = 0;
        for (int k = 0; k < 3; k++) sRa[1][k] = int'(ifB.raddr[k*6 +: 6]);
    endtask

    // Busy lasts exactly nr(d) cycles after the reset or clear edge; once it
    // expires every entry is known to be zero.
    task automatic modelStep(int d);
        if (sReset) begin
            mBusy[d] = 1;
            mLeft[d] = nr(d);
        end else if (mBusy[d]) begin
            mLeft[d]--;
            if (mLeft[d] == 0) begin
                mBusy[d] = 0;
                for (int i = 0; i < 64; i++) mem[d][i] = 32'h0;
            end
        end else begin
            if (sWe0[d] && okAddr(d, sWa0[d])) mem[d][sWa0[d]] = sWd0[d];
            if (sWe1[d] && okAddr(d, sWa1[d])) mem[d][sWa1[d]] = sWd1[d];
            if (sClear) begin
                mBusy[d] = 1;
                mLeft[d] = nr(d);
            end
        end
    endtask

    // Per-cycle comparison against the model, then advance the model.
    always @(negedge clk) begin
        #3;
        snap();
        if (mValid) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (busyOf(d) !== logic'(mBusy[d])) begin
                    failures++;
                    $display("FAIL model_busy dut=%0d t=%0t actual=%b required=%b",
                             d, $time, busyOf(d), mBusy[d]);
                end
                for (int k = 0; k < nrd(d); k++) begin
                    logic [31:0] exp;
                    exp = expRead(d, sRa[d][k]);
                    checks++;
                    if (rd(d, k) !== exp) begin
                        failures++;
                        $display("FAIL model_rdata dut=%0d port=%0d addr=%0d t=%0t actual=%h required=%h",
                                 d, k, sRa[d][k], $time, rd(d, k), exp);
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) modelStep(d);
        if (sReset) mValid = 1;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        reset = 0;
        clear = 0;
        ifA.we0 = 0; ifA.waddr0 = '0; ifA.wdata0 = '0;
        ifA.we1 = 0; ifA.waddr1 = '0; ifA.wdata1 = '0; ifA.raddr = '0;
        ifB.we0 = 0; ifB.waddr0 = '0; ifB.wdata0 = '0;
        ifB.we1 = 0; ifB.waddr1 = '0; ifB.wdata1 = '0; ifB.raddr = '0;
    endtask

    task automatic wr0(int d, int a, logic [31:0] v);
        if (d == 0) begin ifA.we0 = 1; ifA.waddr0 = 5'(a); ifA.wdata0 = v; end
        else        begin ifB.we0 = 1; ifB.waddr0 = 6'(a); ifB.wdata0 = v; end
    endtask

    task automatic wr1(int d, int a, logic [31:0] v);
        if (d == 0) begin ifA.we1 = 1; ifA.waddr1 = 5'(a); ifA.wdata1 = v; end
        else        begin ifB.we1 = 1; ifB.waddr1 = 6'(a); ifB.wdata1 = v; end
    endtask

    task automatic setRa(int d, int k, int a);
        if (d == 0) ifA.raddr[k*5 +: 5] = 5'(a);
        else        ifB.raddr[k*6 +: 6] = 6'(a);
    endtask

    // Counts busy cycles of both instances from the next negedge on.
    task automatic countBusy(output int nA, output int nB);
        bit done;
        nA = 0; nB = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            idle();
            #4;
            if (ifA.busy === 1'b1) nA++;
            if (ifB.busy === 1'b1) nB++;
            if (ifA.busy === 1'b0 && ifB.busy === 1'b0) done = 1;
        end
        if (!done) begin
            failures++;
            $display("FAIL busy_timeout actual=%0d/%0d required=done", nA, nB);
        end
    endtask

    task automatic resetAndCount(output int nA, output int nB);
        @(negedge clk);
        idle();
        reset = 1;
        countBusy(nA, nB);
    endtask

    initial begin
        int nA, nB;
        idle();
        repeat (2) @(negedge clk);

        resetAndCount(nA, nB);
        chk("busy_len_A_after_reset", 32'(nA), 32'd32);
        chk("busy_len_B_after_reset", 32'(nB), 32'd40);

        @(negedge clk); idle();
        setRa(0, 0, 3); setRa(0, 1, 31); setRa(1, 2, 39);
        #4;
        chk("cleared_A_r3", rd(0, 0), 32'h0);
        chk("cleared_A_r31", rd(0, 1), 32'h0);
        chk("cleared_B_r39", rd(1, 2), 32'h0);

        @(negedge clk); idle();
        wr0(0, 5, 32'hDEADBEEF); wr0(1, 5, 32'hDEADBEEF);
        setRa(0, 1, 5); setRa(1, 1, 5);
        #4;
        chk("bypass_A_addr5", rd(0, 1), 32'hDEADBEEF);
        chk("nobypass_B_addr5", rd(1, 1), 32'h0);

        @(negedge clk); idle();
        setRa(0, 0, 5); setRa(1, 0, 5);
        #4;
        chk("stored_A_addr5", rd(0, 0), 32'hDEADBEEF);
        chk("stored_B_addr5", rd(1, 0), 32'hDEADBEEF);

        @(negedge clk); idle();
        for (int d = 0; d < 2; d++) begin
            wr0(d, 7, 32'h11); wr1(d, 7, 32'h22); setRa(d, 0, 7);
        end
        #4;
        chk("dual_bypass_A_addr7", rd(0, 0), 32'h22);
        chk("dual_nobypass_B_addr7", rd(1, 0), 32'h0);

        @(negedge clk); idle();
        setRa(0, 0, 7); setRa(1, 0, 7);
        #4;
        chk("dual_stored_A_addr7", rd(0, 0), 32'h22);
        chk("dual_stored_B_addr7", rd(1, 0), 32'h22);

        @(negedge clk); idle();
        wr1(0, 0, 32'hFFFFFFFF); wr1(1, 0, 32'hFFFFFFFF);
        setRa(0, 0, 0); setRa(1, 0, 0);
        #4;
        chk("zero_reg_bypass_A", rd(0, 0), 32'h0);

        @(negedge clk); idle();
        setRa(0, 0, 0); setRa(1, 0, 0);
        #4;
        chk("zero_reg_stored_A", rd(0, 0), 32'h0);
        chk("no_zero_reg_B_addr0", rd(1, 0), 32'hFFFFFFFF);

        @(negedge clk); idle();
        wr0(1, 40, 32'h12345678); setRa(1, 1, 40);
        #4;
        chk("out_of_range_same_cycle_B", rd(1, 1), 32'h0);

        @(negedge clk); idle();
        setRa(1, 1, 40);
        #4;
        chk("out_of_range_stored_B", rd(1, 1), 32'h0);

        // Soft clear with a write in the same cycle, then a write during busy.
        @(negedge clk); idle();
        clear = 1; setRa(0, 0, 5); wr0(0, 9, 32'h9999);
        #4;
        chk("busy_before_clear_edge", 32'(ifA.busy), 32'h0);
        chk("read_before_clear_edge", rd(0, 0), 32'hDEADBEEF);

        @(negedge clk); idle();
        wr0(0, 9, 32'h5555); wr0(1, 9, 32'h5555); setRa(0, 0, 5);
        #4;
        chk("busy_A_after_clear", 32'(ifA.busy), 32'h1);
        chk("busy_B_after_clear", 32'(ifB.busy), 32'h1);
        chk("read_masked_while_busy", rd(0, 0), 32'h0);

        countBusy(nA, nB);
        chk("busy_len_A_after_clear", 32'(nA + 1), 32'd32);
        chk("busy_len_B_after_clear", 32'(nB + 1), 32'd40);

        @(negedge clk); idle();
        setRa(0, 0, 5); setRa(0, 1, 9); setRa(1, 0, 0); setRa(1, 1, 9);
        #4;
        chk("clear_wiped_A_addr5", rd(0, 0), 32'h0);
        chk("clear_dropped_A_addr9", rd(0, 1), 32'h0);
        chk("clear_wiped_B_addr0", rd(1, 0), 32'h0);
        chk("clear_dropped_B_addr9", rd(1, 1), 32'h0);

        // Reset in the middle of a clear sequence restarts the count.
        @(negedge clk); idle();
        clear = 1;
        repeat (10) begin
            @(negedge clk); idle();
        end
        resetAndCount(nA, nB);
        chk("busy_len_A_reset_mid_clear", 32'(nA), 32'd32);
        chk("busy_len_B_reset_mid_clear", 32'(nB), 32'd40);

        // Randomised traffic, the per-cycle model compare does the checking.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); idle();
            reset = ($urandom_range(0, 599) == 0);
            clear = ($urandom_range(0, 249) == 0);
            for (int d = 0; d < 2; d++) begin
                int top, a0, a1;
                top = (d == 0) ? 31 : 47;
                a0 = $urandom_range(0, top);
                a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, top);
                if ($urandom_range(0, 1) == 1) wr0(d, a0, $urandom);
                if ($urandom_range(0, 2) == 0) wr1(d, a1, $urandom);
                for (int k = 0; k < nrd(d); k++) begin
                    case ($urandom_range(0, 3))
                        0:       setRa(d, k, a0);
                        1:       setRa(d, k, a1);
                        default: setRa(d, k, $urandom_range(0, top));
                    endcase
                end
            end
        end

        @(negedge clk); idle();
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
